matrix_rf_lsu_port: RTL and testbench
=====================================

// Module: matrix_rf_lsu_port
// PURPOSE
//  Matrix register file bank: N_REGS tiles x N_ROWS rows x RLEN bits. It is the responder for the
//  row-granular port pair driven by the matrix LSU adapter.
//  Load side: accepts row writes on a waddr/wrowaddr/we/wready port. Store side: serves row reads
//  on a raddr/rrowaddr/rdata_valid/rdata_ready port at 1 row/cycle, using a prefetching stage register.
//  A compute-unit write port and read port share the array; compute writes have priority over LSU writes.
// PARAMETERS
//  RLEN    128  row width in bits (equals LSU BUS_WIDTH)
//  N_REGS  8    number of matrix tiles (>=2)
//  N_ROWS  4    rows per tile (>=2)
// PORTS
//  clk_i            in   1               clock
//  rst_ni           in   1               asynchronous, active-low reset
//  waddr_i          in   $clog2(N_REGS)  LSU write tile
//  wrowaddr_i       in   $clog2(N_ROWS)  LSU write row
//  wdata_i          in   RLEN            LSU write data
//  we_i             in   1               LSU write request
//  wlast_i          in   1               LSU marks final row of tile
//  wready_o         out  1               LSU write accepted when we_i&wready_o
//  raddr_i          in   $clog2(N_REGS)  LSU read tile
//  rrowaddr_i       in   $clog2(N_ROWS)  LSU read row
//  rdata_o          out  RLEN            LSU read data
//  rdata_valid_o    out  1               rdata_o is the row at (raddr_i,rrowaddr_i)
//  rdata_ready_i    in   1               LSU takes row when rdata_valid_o&rdata_ready_i
//  rlast_i          in   1               LSU marks final row read (qualified by handshake)
//  cwe_i            in   1               compute write enable
//  cwaddr_i/cwrowaddr_i in  tile/row     compute write address
//  cwdata_i         in   RLEN            compute write data
//  craddr_i/crrowaddr_i in  tile/row     compute read address (always enabled)
//  crdata_o         out  RLEN            compute read data, 1-cycle latency
//  load_done_o      out  1               1-cycle pulse: tile fully loaded
//  load_done_reg_o  out  $clog2(N_REGS)  tile index for load_done_o
//  store_done_o     out  1               1-cycle pulse: last store row handed over
//  proto_err_o      out  1               sticky: wlast/rlast on a row != N_ROWS-1
// BEHAVIOUR
//  Reset: all outputs 0; stage register invalid; the array is not reset (contents undefined until written).
//  Write arbitration: wready_o = ~cwe_i (combinational).
//   - An accepted LSU write (we_i&wready_o) updates the row at the next clock edge.
//   - A compute write always updates the row.
//   - Both writes can never target the array in the same cycle, because wready_o is low whenever cwe_i is high.
//  Compute read: crdata_o <= mem[craddr_i][crrowaddr_i] at every edge. Read-before-write: a same-cycle write
//   to that row is not visible until the next read.
//  Store stage register: holds {tag_reg, tag_row, data, vld}.
//   - rdata_valid_o = vld & (tag == {raddr_i, rrowaddr_i}); rdata_o = data.
//   - Update priority, evaluated each edge:
//     1. Any write (LSU accepted or compute) to the row in tag: clear vld (no forwarding). This also applies
//        on a handshake cycle if the write hits the prefetched row.
//     2. Handshake with !rlast_i: prefetch the row at {raddr_i, (rrowaddr_i+1) mod N_ROWS}.
//     3. Handshake with rlast_i: clear vld.
//     4. Tag mismatch or !vld: fetch mem[raddr_i][rrowaddr_i]; set vld; tag = current address.
//   - A fetch whose address row is being written in the same cycle latches old data. It must be marked
//     invalid, so a refetch follows next cycle.
//   - Latency: the first row is valid 1 cycle after the address is presented. Streaming then delivers
//     1 row/cycle while rdata_ready_i is held high.
//  load_done_o/load_done_reg_o: registered, asserted the cycle after an accepted write with wlast_i.
//  store_done_o: registered, asserted the cycle after rdata_valid_o&rdata_ready_i&rlast_i.
//  proto_err_o: set if an accepted write has wlast_i with wrowaddr_i != N_ROWS-1, or a handshake has rlast_i
//   with rrowaddr_i != N_ROWS-1. It is cleared only by reset.
//  Address wrap: a row index of N_ROWS-1 plus 1 wraps to 0. Tile indexes >= N_REGS are undefined; assert in simulation.
//  Reset mid-stream: the stage register is invalidated and pulses are dropped. The array keeps its contents
//   (no requirement).
// TESTING
//  1. Load tile 3 rows 0..3 with data 0xA0..A3, we_i held high, wlast_i on row 3
//     -> 4 accepts in 4 cycles; load_done_o=1 with reg=3 one cycle later.
//  2. Store tile 3 with rdata_ready_i=1 -> valid at cycle 1, then rows 0xA0,A1,A2,A3 on 4 consecutive cycles;
//     store_done_o the cycle after row 3.
//  3. cwe_i high for 2 cycles during an LSU load -> wready_o low for those 2 cycles;
//     the LSU row is written only after acceptance; the compute row is written.
//  4. Compute write to tile 3 row 1 (0x55) while that row is staged -> rdata_valid_o drops for 1 cycle,
//     then returns with 0x55.
//  5. rdata_ready_i toggling 1,0,1,0 -> no row duplicated or skipped; the row order is unchanged.
//  6. wlast_i on row 2 -> proto_err_o=1 and it stays set until rst_ni goes low;
//     a reset mid-stream clears rdata_valid_o immediately.

Source files
------------

// File: rtl/matrix_rf_lsu_port_if.sv
// LSU <-> matrix register file row port: load (row write) and store (row read) channels.
// Latency: wiring only.
// Backpressure: writes stall on wready; reads complete on rdata_valid & rdata_ready.
// Ports: master = LSU adapter side, slave = register file side.
interface matrix_rf_lsu_port_if #(
  parameter int RLEN   = 128,
  parameter int N_REGS = 8,
  parameter int N_ROWS = 4
);
  localparam int TW = $clog2(N_REGS);
  localparam int RW = $clog2(N_ROWS);

  // load side
  logic [TW-1:0]   waddr;
  logic [RW-1:0]   wrowaddr;
  logic [RLEN-1:0] wdata;
  logic            we;
  logic            wlast;
  logic            wready;
  // store side
  logic [TW-1:0]   raddr;
  logic [RW-1:0]   rrowaddr;
  logic [RLEN-1:0] rdata;
  logic            rdata_valid;
  logic            rdata_ready;
  logic            rlast;

  modport master (
    output waddr, wrowaddr, wdata, we, wlast,
    output raddr, rrowaddr, rdata_ready, rlast,
    input  wready, rdata, rdata_valid
  );

  modport slave (
    input  waddr, wrowaddr, wdata, we, wlast,
    input  raddr, rrowaddr, rdata_ready, rlast,
    output wready, rdata, rdata_valid
  );
endinterface

// File: rtl/matrix_rf_lsu_port.sv
// Matrix register file bank (N_REGS tiles x N_ROWS rows x RLEN) serving the LSU row port and a compute port.
// Latency: LSU write lands next edge; first store row valid 1 cycle after address, then 1 row/cycle; compute read 1 cycle.
// Backpressure: wready drops while compute writes; store stage holds its row until rdata_ready.
// Ports: clk_i/rst_ni; lsu (slave modport of matrix_rf_lsu_port_if); compute write (cwe/cwaddr/cwrowaddr/cwdata);
//        compute read (craddr/crrowaddr -> crdata); status pulses load_done(_reg), store_done; sticky proto_err.
module matrix_rf_lsu_port #(
  parameter int RLEN   = 128,
  parameter int N_REGS = 8,
  parameter int N_ROWS = 4,
  localparam int TW    = $clog2(N_REGS),
  localparam int RW    = $clog2(N_ROWS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  matrix_rf_lsu_port_if.slave lsu,
  input  logic                cwe_i,
  input  logic [TW-1:0]       cwaddr_i,
  input  logic [RW-1:0]       cwrowaddr_i,
  input  logic [RLEN-1:0]     cwdata_i,
  input  logic [TW-1:0]       craddr_i,
  input  logic [RW-1:0]       crrowaddr_i,
  output logic [RLEN-1:0]     crdata_o,
  output logic                load_done_o,
  output logic [TW-1:0]       load_done_reg_o,
  output logic                store_done_o,
  output logic                proto_err_o
);

  localparam logic [RW-1:0] LAST_ROW = RW'(N_ROWS - 1);

  typedef struct packed {
    logic [TW-1:0]   tile;
    logic [RW-1:0]   row;
    logic [RLEN-1:0] data;
    logic            vld;
  } stage_t;

  logic [RLEN-1:0] mem_q [N_REGS][N_ROWS];

  stage_t          stage_d, stage_q;
  logic [RLEN-1:0] crdata_q;
  logic            load_done_d, load_done_q;
  logic [TW-1:0]   load_done_reg_d, load_done_reg_q;
  logic            store_done_d, store_done_q;
  logic            proto_err_d, proto_err_q;

  logic            lsu_acc, wr_vld, hs, tag_hit;
  logic [TW-1:0]   wr_tile, fetch_tile;
  logic [RW-1:0]   wr_row, fetch_row, row_inc;
  logic [RLEN-1:0] wr_data;
  logic            stage_wr_hit, fetch_wr_hit;

  // Compute owns the single array write port whenever it asks; the LSU is simply told to wait.
  assign lsu.wready = ~cwe_i;
  assign lsu_acc    = lsu.we & ~cwe_i;
  assign wr_vld     = cwe_i | lsu_acc;
  assign wr_tile    = cwe_i ? cwaddr_i    : lsu.waddr;
  assign wr_row     = cwe_i ? cwrowaddr_i : lsu.wrowaddr;
  assign wr_data    = cwe_i ? cwdata_i    : lsu.wdata;

  always_ff @(posedge clk_i) begin
    if (wr_vld) mem_q[wr_tile][wr_row] <= wr_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) crdata_q <= '0;
    else         crdata_q <= mem_q[craddr_i][crrowaddr_i];
  end
  assign crdata_o = crdata_q;

  // Store stage: the row is only presented while its tag matches the address the LSU drives now.
  assign tag_hit         = (stage_q.tile == lsu.raddr) && (stage_q.row == lsu.rrowaddr);
  assign lsu.rdata_valid = stage_q.vld & tag_hit;
  assign lsu.rdata       = stage_q.data;
  assign hs              = lsu.rdata_valid & lsu.rdata_ready;

  assign row_inc    = (lsu.rrowaddr == LAST_ROW) ? '0 : lsu.rrowaddr + RW'(1);
  // On a handshake we prefetch the row the LSU will ask for next; otherwise we fetch what it asks for now.
  assign fetch_tile = lsu.raddr;
  assign fetch_row  = hs ? row_inc : lsu.rrowaddr;

  assign stage_wr_hit = stage_q.vld && wr_vld && (wr_tile == stage_q.tile) && (wr_row == stage_q.row);
  // The array read sees pre-write data, so a fetch colliding with a write must not be trusted.
  assign fetch_wr_hit = wr_vld && (wr_tile == fetch_tile) && (wr_row == fetch_row);

  always_comb begin
    stage_d = stage_q;
    if (stage_wr_hit) begin
      stage_d.vld = 1'b0;
    end else if ((hs && !lsu.rlast) || !lsu.rdata_valid) begin
      stage_d.tile = fetch_tile;
      stage_d.row  = fetch_row;
      stage_d.data = mem_q[fetch_tile][fetch_row];
      stage_d.vld  = ~fetch_wr_hit;
    end else if (hs) begin
      stage_d.vld = 1'b0;
    end
  end

  always_comb begin
    load_done_d     = lsu_acc & lsu.wlast;
    load_done_reg_d = load_done_d ? lsu.waddr : load_done_reg_q;
    store_done_d    = hs & lsu.rlast;
    proto_err_d     = proto_err_q
                    | (lsu_acc & lsu.wlast & (lsu.wrowaddr != LAST_ROW))
                    | (hs & lsu.rlast & (lsu.rrowaddr != LAST_ROW));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q         <= '0;
      load_done_q     <= 1'b0;
      load_done_reg_q <= '0;
      store_done_q    <= 1'b0;
      proto_err_q     <= 1'b0;
    end else begin
      stage_q         <= stage_d;
      load_done_q     <= load_done_d;
      load_done_reg_q <= load_done_reg_d;
      store_done_q    <= store_done_d;
      proto_err_q     <= proto_err_d;
    end
  end

  assign load_done_o     = load_done_q;
  assign load_done_reg_o = load_done_reg_q;
  assign store_done_o    = store_done_q;
  assign proto_err_o     = proto_err_q;

  // Tile indexes past N_REGS are only representable when N_REGS is not a power of two.
  if (N_REGS != (1 << TW)) begin : g_tile_chk
    a_tile_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (32'(lsu.waddr) < N_REGS) && (32'(lsu.raddr) < N_REGS) &&
      (32'(cwaddr_i) < N_REGS) && (32'(craddr_i) < N_REGS));
  end

endmodule

// File: tb/tb_matrix_rf_lsu_port.sv
module tb_matrix_rf_lsu_port;
  localparam int RLEN = 128, N_REGS = 8, N_ROWS = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            cwe_i = 1'b0;
  logic [2:0]      cwaddr_i = '0, craddr_i = '0;
  logic [1:0]      cwrowaddr_i = '0, crrowaddr_i = '0;
  logic [RLEN-1:0] cwdata_i = '0;
  logic [RLEN-1:0] crdata_o;
  logic            load_done_o, store_done_o, proto_err_o;
  logic [2:0]      load_done_reg_o;

  matrix_rf_lsu_port_if #(.RLEN(RLEN), .N_REGS(N_REGS), .N_ROWS(N_ROWS)) lsu_if ();

  matrix_rf_lsu_port #(.RLEN(RLEN), .N_REGS(N_REGS), .N_ROWS(N_ROWS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .lsu(lsu_if),
    .cwe_i(cwe_i), .cwaddr_i(cwaddr_i), .cwrowaddr_i(cwrowaddr_i), .cwdata_i(cwdata_i),
    .craddr_i(craddr_i), .crrowaddr_i(crrowaddr_i), .crdata_o(crdata_o),
    .load_done_o(load_done_o), .load_done_reg_o(load_done_reg_o),
    .store_done_o(store_done_o), .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0, miscompares = 0;

  // reference model: array contents plus expected registered outputs
  logic [RLEN-1:0] ref_mem [N_REGS][N_ROWS];
  bit              known   [N_REGS][N_ROWS];
  logic [RLEN-1:0] exp_cr;
  bit              cr_known;
  bit              exp_ld, exp_sd, exp_perr;
  logic [2:0]      exp_ldreg;

  // values sampled at the falling edge of the last cycle
  logic            s_wready, s_valid, s_ld, s_sd, s_perr;
  logic [RLEN-1:0] s_rdata, s_cr;
  logic [2:0]      s_ldreg;

  task automatic chk(input string tag, input logic [RLEN-1:0] obs, input logic [RLEN-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 128'(obs), 128'(exp));
  endtask

  // One clock cycle: sample and check outputs, advance the model across the edge.
  task automatic cyc();
    logic acc, hs;
    @(negedge clk_i);
    s_wready = lsu_if.wready;   s_valid = lsu_if.rdata_valid; s_rdata = lsu_if.rdata;
    s_cr     = crdata_o;        s_ld    = load_done_o;        s_ldreg = load_done_reg_o;
    s_sd     = store_done_o;    s_perr  = proto_err_o;
    chk1("wready", s_wready, !cwe_i);
    if (s_valid && known[lsu_if.raddr][lsu_if.rrowaddr])
      chk("rdata", s_rdata, ref_mem[lsu_if.raddr][lsu_if.rrowaddr]);
    if (cr_known) chk("crdata", s_cr, exp_cr);
    chk1("load_done", s_ld, exp_ld);
    if (exp_ld) chk("load_done_reg", 128'(s_ldreg), 128'(exp_ldreg));
    chk1("store_done", s_sd, exp_sd);
    chk1("proto_err", s_perr, exp_perr);

    acc      = lsu_if.we && !cwe_i;
    hs       = s_valid && lsu_if.rdata_ready;
    exp_cr   = ref_mem[craddr_i][crrowaddr_i];
    cr_known = known[craddr_i][crrowaddr_i];
    exp_ld   = acc && lsu_if.wlast;
    if (exp_ld) exp_ldreg = lsu_if.waddr;
    exp_sd   = hs && lsu_if.rlast;
    if ((acc && lsu_if.wlast && lsu_if.wrowaddr != 2'd3) || (hs && lsu_if.rlast && lsu_if.rrowaddr != 2'd3))
      exp_perr = 1'b1;
    if (cwe_i) begin
      ref_mem[cwaddr_i][cwrowaddr_i] = cwdata_i;
      known[cwaddr_i][cwrowaddr_i]   = 1'b1;
    end else if (acc) begin
      ref_mem[lsu_if.waddr][lsu_if.wrowaddr] = lsu_if.wdata;
      known[lsu_if.waddr][lsu_if.wrowaddr]   = 1'b1;
    end
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #1;
    chk1("rst_rdata_valid", lsu_if.rdata_valid, 1'b0);
    chk("rst_rdata", lsu_if.rdata, '0);
    chk("rst_crdata", crdata_o, '0);
    chk1("rst_load_done", load_done_o, 1'b0);
    chk("rst_load_done_reg", 128'(load_done_reg_o), '0);
    chk1("rst_store_done", store_done_o, 1'b0);
    chk1("rst_proto_err", proto_err_o, 1'b0);
    exp_cr = '0; cr_known = 1'b1; exp_ld = 0; exp_sd = 0; exp_perr = 0; exp_ldreg = '0;
    rst_ni = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int row, k;
    logic [RLEN-1:0] got [$];
    logic [RLEN-1:0] exp_seq [4];

    foreach (known[t, r]) begin known[t][r] = 1'b0; ref_mem[t][r] = '0; end
    lsu_if.we = 0; lsu_if.wlast = 0; lsu_if.waddr = '0; lsu_if.wrowaddr = '0; lsu_if.wdata = '0;
    lsu_if.raddr = '0; lsu_if.rrowaddr = '0; lsu_if.rdata_ready = 0; lsu_if.rlast = 0;
    #1;
    do_reset();
    cyc(); cyc();

    // 1: load tile 3, back-to-back rows
    for (int r = 0; r < 4; r++) begin
      lsu_if.we = 1; lsu_if.waddr = 3'd3; lsu_if.wrowaddr = 2'(r);
      lsu_if.wdata = 128'(32'hA0 + r); lsu_if.wlast = (r == 3);
      cyc();
      chk1("t1_accept", s_wready, 1'b1);
    end
    lsu_if.we = 0; lsu_if.wlast = 0;
    cyc();
    chk1("t1_load_done", s_ld, 1'b1);
    chk("t1_load_done_reg", 128'(s_ldreg), 128'(3));

    // 2: stream tile 3 out with ready held high
    lsu_if.raddr = 3'd3; lsu_if.rrowaddr = 2'd0; lsu_if.rdata_ready = 1;
    cyc();
    chk1("t2_first_cycle_invalid", s_valid, 1'b0);
    for (int r = 0; r < 4; r++) begin
      lsu_if.rrowaddr = 2'(r); lsu_if.rlast = (r == 3);
      cyc();
      chk1("t2_valid", s_valid, 1'b1);
      chk("t2_row", s_rdata, 128'(32'hA0 + r));
    end
    lsu_if.rdata_ready = 0; lsu_if.rlast = 0;
    cyc();
    chk1("t2_store_done", s_sd, 1'b1);

    // 3: compute writes stall an LSU load of tile 5
    row = 0; k = 0;
    while (row < 4 && k < 12) begin
      lsu_if.we = 1; lsu_if.waddr = 3'd5; lsu_if.wrowaddr = 2'(row);
      lsu_if.wdata = 128'(32'h50 + row); lsu_if.wlast = (row == 3);
      cwe_i = (k == 1 || k == 2); cwaddr_i = 3'd6; cwrowaddr_i = 2'd2; cwdata_i = 128'(32'hC0 + k);
      cyc();
      if (k == 1 || k == 2) chk1("t3_wready_low", s_wready, 1'b0);
      if (s_wready) row++;
      k++;
    end
    lsu_if.we = 0; lsu_if.wlast = 0; cwe_i = 0;
    chk("t3_cycles", 128'(k), 128'(6));
    cyc();
    chk1("t3_load_done", s_ld, 1'b1);
    chk("t3_load_done_reg", 128'(s_ldreg), 128'(5));
    craddr_i = 3'd6; crrowaddr_i = 2'd2;
    cyc(); cyc();
    chk("t3_compute_row", s_cr, 128'(32'hC2));
    for (int r = 0; r < 4; r++) begin
      craddr_i = 3'd5; crrowaddr_i = 2'(r);
      cyc(); cyc();
      chk("t3_lsu_row", s_cr, 128'(32'h50 + r));
    end

    // 4: compute write hits the staged row
    lsu_if.raddr = 3'd3; lsu_if.rrowaddr = 2'd1; lsu_if.rdata_ready = 0;
    cyc(); cyc();
    chk1("t4_staged", s_valid, 1'b1);
    chk("t4_staged_data", s_rdata, 128'(32'hA1));
    cwe_i = 1; cwaddr_i = 3'd3; cwrowaddr_i = 2'd1; cwdata_i = 128'(32'h55);
    cyc();
    chk1("t4_valid_during_write", s_valid, 1'b1);
    cwe_i = 0;
    cyc();
    chk1("t4_valid_dropped", s_valid, 1'b0);
    cyc();
    chk1("t4_valid_back", s_valid, 1'b1);
    chk("t4_new_data", s_rdata, 128'(32'h55));

    // 5: ready toggling, rows must arrive in order without gaps or repeats
    exp_seq[0] = 128'(32'hA0); exp_seq[1] = 128'(32'h55);
    exp_seq[2] = 128'(32'hA2); exp_seq[3] = 128'(32'hA3);
    row = 0;
    for (int c = 0; c < 40 && row < 4; c++) begin
      lsu_if.rrowaddr = 2'(row); lsu_if.rdata_ready = (c % 2 == 0); lsu_if.rlast = (row == 3);
      cyc();
      if (s_valid && lsu_if.rdata_ready) begin got.push_back(s_rdata); row++; end
    end
    lsu_if.rdata_ready = 0; lsu_if.rlast = 0;
    chk("t5_row_count", 128'(got.size()), 128'(4));
    for (int i = 0; i < 4; i++)
      if (i < got.size()) chk("t5_row_order", got[i], exp_seq[i]);

    // 6: wlast on a non-final row, then reset mid-stream
    lsu_if.we = 1; lsu_if.waddr = 3'd1; lsu_if.wrowaddr = 2'd2; lsu_if.wdata = 128'(32'h12); lsu_if.wlast = 1;
    cyc();
    lsu_if.we = 0; lsu_if.wlast = 0;
    cyc();
    chk1("t6_proto_err", s_perr, 1'b1);
    chk("t6_load_done_reg", 128'(s_ldreg), 128'(1));
    repeat (3) cyc();
    chk1("t6_proto_err_sticky", s_perr, 1'b1);
    lsu_if.raddr = 3'd3; lsu_if.rrowaddr = 2'd0;
    cyc(); cyc();
    chk1("t6_streaming", s_valid, 1'b1);
    rst_ni = 1'b0; #1;
    chk1("t6_rst_valid_async", lsu_if.rdata_valid, 1'b0);
    chk1("t6_rst_proto_err", proto_err_o, 1'b0);
    do_reset();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cwe_i = ($urandom_range(0, 3) == 0);
      cwaddr_i = 3'($urandom_range(0, 7)); cwrowaddr_i = 2'($urandom_range(0, 3));
      cwdata_i = {$urandom, $urandom, $urandom, $urandom};
      lsu_if.we = 1'($urandom_range(0, 1));
      lsu_if.waddr = 3'($urandom_range(0, 7)); lsu_if.wrowaddr = 2'($urandom_range(0, 3));
      lsu_if.wdata = {$urandom, $urandom, $urandom, $urandom};
      lsu_if.wlast = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        lsu_if.raddr = 3'($urandom_range(0, 7)); lsu_if.rrowaddr = 2'($urandom_range(0, 3));
      end
      lsu_if.rdata_ready = 1'($urandom_range(0, 1));
      lsu_if.rlast = (lsu_if.rrowaddr == 2'd3) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      craddr_i = 3'($urandom_range(0, 7)); crrowaddr_i = 2'($urandom_range(0, 3));
      cyc();
      if (s_valid && lsu_if.rdata_ready && !lsu_if.rlast) lsu_if.rrowaddr = lsu_if.rrowaddr + 2'd1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
